// File: rtl/operand_fetch.sv
// Operand-fetch stage: register file with write-back bypass, registered ALU
// operands/opcode with stall refresh, and a registered zero flag.
module operand_fetch #(
   parameter int W  = 8,
   parameter int A  = 3,
   parameter int IW = 4
) (
   input  logic          CLK,
   input  logic          Reset,
   input  logic          IssueValid,
   input  logic          Stall,
   input  logic [A-1:0]  RdAddrA,
   input  logic [A-1:0]  RdAddrB,
   input  logic          ImmSel,
   input  logic [IW-1:0] Imm,
   input  logic [1:0]    ALUOpIn,
   input  logic          WrEn,
   input  logic [A-1:0]  WrAddr,
   input  logic [W-1:0]  WrData,
   input  logic          FlagWrEn,
   output logic [W-1:0]  ALUSrcA,
   output logic [W-1:0]  ALUSrcB,
   output logic [1:0]    ALUOp,
   output logic          OperandValid,
   output logic          ZeroFlag
);

   localparam int DEPTH = 1 << A;

   logic [W-1:0] rf_q [DEPTH];

   logic [W-1:0] alu_src_a_q, alu_src_a_d;
   logic [W-1:0] alu_src_b_q, alu_src_b_d;
   logic [1:0]   alu_op_q, alu_op_d;
   logic         valid_q, valid_d;
   logic         zero_q, zero_d;
   logic [A-1:0] addr_a_q, addr_a_d;
   logic [A-1:0] addr_b_q, addr_b_d;
   logic         imm_sel_q, imm_sel_d;

   logic [W-1:0] src_a, src_b;
   logic         wr_live, refresh_a, refresh_b;

   assign wr_live = WrEn && (WrAddr != '0);

   // Read ports: r0 reads as zero; a same-cycle write to the source wins over the array.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      src_a = '0;
      src_b = '0;
      if (RdAddrA != '0) begin
         src_a = (WrEn && (WrAddr == RdAddrA)) ? WrData : rf_q[RdAddrA];
      end
      if (ImmSel) begin
         src_b = {{(W-IW){1'b0}}, Imm};
      end else if (RdAddrB != '0) begin
         src_b = (WrEn && (WrAddr == RdAddrB)) ? WrData : rf_q[RdAddrB];
      end
   end

   assign refresh_a = wr_live && (WrAddr == addr_a_q);
   assign refresh_b = wr_live && (WrAddr == addr_b_q) && !imm_sel_q;

   // Stall outranks issue; a stalled operand only changes when its source is rewritten.
   always_comb begin
      alu_src_a_d = alu_src_a_q;
      alu_src_b_d = alu_src_b_q;
      alu_op_d    = alu_op_q;
      valid_d     = valid_q;
      addr_a_d    = addr_a_q;
      addr_b_d    = addr_b_q;
      imm_sel_d   = imm_sel_q;
      zero_d      = zero_q;

      if (Stall) begin
         if (refresh_a) alu_src_a_d = WrData;
         if (refresh_b) alu_src_b_d = WrData;
      end else if (IssueValid) begin
         alu_src_a_d = src_a;
         alu_src_b_d = src_b;
         alu_op_d    = ALUOpIn;
         valid_d     = 1'b1;
         addr_a_d    = RdAddrA;
         addr_b_d    = RdAddrB;
         imm_sel_d   = ImmSel;
      end else begin
         valid_d     = 1'b0;
      end

      if (WrEn && FlagWrEn) zero_d = (WrData == '0);
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         // NOTE: the register file is architecturally cleared by reset, so the
         // array is reset here instead of being left as uninitialised RAM.
         for (int i = 0; i < DEPTH; i++) rf_q[i] <= '0;
         alu_src_a_q <= '0;
         alu_src_b_q <= '0;
         alu_op_q    <= '0;
         valid_q     <= 1'b0;
         zero_q      <= 1'b0;
         addr_a_q    <= '0;
         addr_b_q    <= '0;
         imm_sel_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep every read in this edge on pre-edge values.
         if (wr_live) rf_q[WrAddr] <= WrData;
         alu_src_a_q <= alu_src_a_d;
         alu_src_b_q <= alu_src_b_d;
         alu_op_q    <= alu_op_d;
         valid_q     <= valid_d;
         zero_q      <= zero_d;
         addr_a_q    <= addr_a_d;
         addr_b_q    <= addr_b_d;
         imm_sel_q   <= imm_sel_d;
      end
   end

   assign ALUSrcA      = alu_src_a_q;
   assign ALUSrcB      = alu_src_b_q;
   assign ALUOp        = alu_op_q;
   assign OperandValid = valid_q;
   assign ZeroFlag     = zero_q;

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Operand-fetch stage sitting directly upstream of the 8-bit ALU. It holds the architectural register file, selects register or immediate operands, and presents registered `ALUSrcA`, `ALUSrcB` and `ALUOp` to the ALU one cycle after issue. It also accepts the ALU result back as the write-back port, with same-cycle bypass, and keeps a registered zero flag derived from written-back results.

## Interface
- `W`, 8: datapath width; matches ALU operand width.
- `A`, 3: register address width; register file depth is 2^A.
- `IW`, 4: immediate width; zero-extended to `W`.

- `CLK` in 1: clock; all state updates on rising edge.
- `Reset` in 1: synchronous, active-high reset.
- `IssueValid` in 1: decode presents a valid instruction this cycle.
- `Stall` in 1: downstream not ready; hold the operand register.
- `RdAddrA` in A: source register for operand A.
- `RdAddrB` in A: source register for operand B.
- `ImmSel` in 1: 1 means operand B is the immediate; 0 means it is the register.
- `Imm` in IW: immediate value.
- `ALUOpIn` in 2: ALU opcode (00 AND, 01 ADD, 10 XOR, 11 SUB), passed through.
- `WrEn` in 1: write-back enable.
- `WrAddr` in A: write-back destination.
- `WrData` in W: write-back data (ALU Result).
- `FlagWrEn` in 1: update `ZeroFlag` on this write-back.
- `ALUSrcA` out W: registered operand A.
- `ALUSrcB` out W: registered operand B.
- `ALUOp` out 2: registered opcode.
- `OperandValid` out 1: outputs hold a valid issued instruction.
- `ZeroFlag` out 1: 1 when the last flagged write-back was 0.

## Operation
- Register file: 2^A entries of W bits.
  - r0 is hardwired to 0: writes to address 0 are discarded and reads of address 0 return 0.
  - Register write occurs on the rising edge when `WrEn` is high, independent of `Stall` and `IssueValid`.
- Operand read with bypass:
  - srcA = 0 if `RdAddrA` is 0.
  - Otherwise srcA = `WrData` if `WrEn` is high and `WrAddr` equals `RdAddrA`.
  - Otherwise srcA = rf[`RdAddrA`].
  - srcB is the same rule applied to `RdAddrB`, unless `ImmSel` is high, in which case srcB = {zeros, `Imm`}.
- Issue (`IssueValid` high, `Stall` low):
  - Latch srcA, srcB and `ALUOpIn` into the outputs, and set `OperandValid` high.
  - Internally latch `RdAddrA`, `RdAddrB` and `ImmSel` for stall refresh.
- Bubble (`IssueValid` low, `Stall` low): `OperandValid` goes low and the data outputs hold their previous value.
- Stall (`Stall` high): `OperandValid`, `ALUOp` and the operand outputs hold, with one exception, stall refresh.
  - If `WrEn` is high, `WrAddr` is nonzero and `WrAddr` equals a latched source address, that held operand is replaced by `WrData`.
  - Operand B is only refreshed when the latched `ImmSel` is 0.
  - `IssueValid` is ignored while `Stall` is high; decode must hold its instruction.
- Zero flag: when `WrEn` and `FlagWrEn` are both high, `ZeroFlag` takes the value (`WrData` == 0).
  - This update happens even when `WrAddr` is 0.
  - Otherwise `ZeroFlag` holds.
- Priority: `Reset` first, then `Stall`, then issue, then bubble.

## Timing
- Reset (synchronous, takes effect at the edge where `Reset` is high):
  - All registers become 0, `ALUSrcA` and `ALUSrcB` become 0, `ALUOp` becomes 00, `OperandValid` becomes 0 and `ZeroFlag` becomes 0.
  - A write-back or issue in the same cycle as `Reset` is discarded.
- Latency: instruction issued at edge N appears on the outputs after edge N, so the ALU result is available in cycle N+1.
- Write-to-read: a write at edge N is visible to an issue sampled at that same edge N via the bypass. There is no bubble required.
- Simultaneous write to the same address on A and B with `ImmSel` low: both operands receive `WrData`.
- Sustained `Stall`: outputs remain stable for any number of cycles apart from refresh; refresh is applied on every edge with a matching write.
- A write to a register not latched as a source during `Stall` does not change the outputs.

## Test plan
- Reset mid-stream: after several writes, assert `Reset` for one cycle → all outputs are 0, and a read of every register issued next yields 0.
- Write r3=0x5A, then issue A=r3, B=Imm 0xF with op 01 → next cycle `ALUSrcA`=0x5A, `ALUSrcB`=0x0F, `ALUOp`=01, `OperandValid`=1.
- Bypass: in the same cycle, write r2=0x33 and issue A=r2, B=r2 → next cycle both operands are 0x33. Writing r0=0xFF and then reading r0 → 0x00.
- Stall refresh: issue A=r4 (0x10), B=r5, then raise `Stall` and write r4=0x77 → `ALUSrcA` becomes 0x77, `ALUSrcB` is unchanged, and `OperandValid` stays 1. A write to r6 during the stall → no output change.
- Bubble: issue once, then drop `IssueValid` → `OperandValid`=0 after one edge with operands held. Re-assert `IssueValid` → `OperandValid`=1.
- Zero flag: write-back 0x00 with `FlagWrEn` → `ZeroFlag`=1. Write-back 0x01 without `FlagWrEn` → still 1. Write-back 0x01 with `FlagWrEn` to r0 → `ZeroFlag`=0.
